serial_sub: RTL
===============

// Module: serial_sub
// PURPOSE
//  Bit-serial N-bit subtractor z = x - y - bin, the inverse datapath to the 2-bit ripple adder.
//  Operates LSB first, one bit per clock, through a single full-subtractor cell and a borrow flop.
//  Uses a start/busy/done handshake.
//  Sits beside the adder blocks in the lab ALU path as a low-area sequential SUB unit.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk    in   1      single clock, rising edge
//  rst_n  in   1      asynchronous, active-low reset
//  start  in   1      request; sampled on rising clk edge, honoured only in IDLE or DONE
//  x      in   WIDTH  minuend, captured on accepted start
//  y      in   WIDTH  subtrahend, captured on accepted start
//  bin    in   1      borrow-in, captured on accepted start
//  busy   out  1      high while state is RUN
//  done   out  1      one-cycle pulse: z/bout valid
//  z      out  WIDTH  difference; held from done until next accepted start
//  bout   out  1      borrow-out (1 = x < y+bin unsigned); held with z
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - state=IDLE, busy=0, done=0, z=0, bout=0, all shift regs/counter cleared
//  FSM: IDLE, RUN, DONE
//   - IDLE: start=1 -> load xs<=x, ys<=y, brw<=bin, cnt<=0, z<=0; go to RUN
//   - RUN, each edge:
//     - d = xs[0]^ys[0]^brw
//     - brw <= (~xs[0]&ys[0]) | (~xs[0]&brw) | (ys[0]&brw)
//     - xs, ys shift right by 1
//     - z <= {d, z[WIDTH-1:1]}
//     - cnt++
//   - RUN: when cnt==WIDTH-1, that edge processes the final bit; go to DONE, bout<=new brw
//   - DONE: done=1 for exactly this cycle. start=1 -> reload and go to RUN (back-to-back ops); else go to IDLE
//  Latency
//   - start sampled at edge E0; bits processed at E1..E_WIDTH
//   - done high in the cycle after E_WIDTH; results are registered outputs
//   - throughput: one op per WIDTH+1 cycles
//  Boundary conditions
//   - start while RUN: ignored; no operand recapture
//   - x/y/bin changes after capture: no effect on the current op
//   - z and bout change only on accepted start (z cleared) or during RUN/DONE entry; stable in IDLE
//   - result is mod 2^WIDTH (wrap-around); bout reports the underflow
//   - rst_n low mid-RUN: abort immediately; outputs return to reset values; no done pulse
//   - cnt width = $clog2(WIDTH); no overflow past WIDTH-1
// STRUCTURE
//  - Sub-module fsc (full-subtractor cell): inputs x, y, bin; outputs d, bout; combinational only
//  - Shared package: typedef enum {IDLE, RUN, DONE} for the state; localparam CNT_W
//  - serial_sub holds the FSM, shift registers, counter and borrow flop
// TESTING (WIDTH=8 unless noted; bench drives start for one cycle)
//  1. x=8'h5A, y=8'h3C, bin=0 -> done exactly 9 edges after start edge; z=8'h1E, bout=0
//  2. x=8'h00, y=8'h01, bin=0 -> z=8'hFF, bout=1 (wrap-around/underflow)
//  3. x=8'hFF, y=8'hFF, bin=1 -> z=8'hFF, bout=1; then x=8'h80, y=8'h7F, bin=0 -> z=8'h01, bout=0
//  4. start pulsed again 3 cycles into RUN with new x/y -> ignored; original result; single done
//  5. rst_n low 4 cycles into RUN -> busy=0, z=0, bout=0 at once, no done; next op correct
//  6. WIDTH=2: exhaustive 32 {x,y,bin} combos, back-to-back starts from DONE -> {bout,z} == {1'b0,x}-y-bin each time

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width for a given operand width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_sub_fsc.sv
// Full-subtractor cell: one bit of x - y - bin.
module fsc (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generated by this bit position.
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor z = x - y - bin, LSB first, one bit per clock.
module serial_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             bout
);

    import serial_sub_pkg::*;

    localparam int unsigned CNT_BITS = cnt_width(WIDTH);
    localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(WIDTH - 1);

    state_t              state;
    logic [WIDTH-1:0]    xs;
    logic [WIDTH-1:0]    ys;
    logic                brw;
    logic [CNT_BITS-1:0] cnt;

    logic                d_c;
    logic                brw_nxt_c;
    logic                accept_c;

    // Single subtractor cell fed from the LSBs of the operand shifters.
    fsc u_fsc (
        .x    (xs[0]),
        .y    (ys[0]),
        .bin  (brw),
        .d    (d_c),
        .bout (brw_nxt_c)
    );

    // A new operation is only taken when not mid-computation.
    assign accept_c = start && ((state == IDLE) || (state == DONE));

    // Control FSM, operand shifters, borrow flop and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            xs    <= '0;
            ys    <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            z     <= '0;
            bout  <= 1'b0;
        end else if (accept_c) begin
            state <= RUN;
            xs    <= x;
            ys    <= y;
            brw   <= bin;
            cnt   <= '0;
            z     <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                RUN: begin
                    xs  <= xs >> 1;
                    ys  <= ys >> 1;
                    brw <= brw_nxt_c;
                    z   <= {d_c, z[WIDTH-1:1]};
                    cnt <= cnt + CNT_BITS'(1);
                    if (cnt == LAST_BIT) begin
                        state <= DONE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bout  <= brw_nxt_c;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
